frame_buf_writer: RTL and testbench

Write-side scheduler for the ping-pong frame memory that the serial frame generator reads. It fills the 256-word bank the generator is not reading, using a fixed slot commutation: address `a` belongs to source `a % N_SRC`. Each slot waits a bounded time for its source and writes a filler word if the source misses. The block follows the generator's bank toggle and reports late banks and missed slots per bank.

---
 rtl/m16_pkg.sv | 17 +
 rtl/frame_buf_writer_slot_timer.sv | 42 ++++
 rtl/frame_buf_writer.sv | 163 ++++++++++++++++
 tb/tb_frame_buf_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m16_pkg.sv
// Shared types and defaults for the ping-pong frame memory write side.
package m16_pkg;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam logic [DATA_W-1:0] FILL_WORD = 12'h000;

  typedef enum logic {
    WAIT = 1'b0,
    DONE = 1'b1
  } wr_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_buf_writer_slot_timer.sv
// Per-slot wait budget: reloads to TMO-1, counts down while enabled and
// flags expiry in the last allowed cycle of the slot.
module slot_timer #(
  parameter int TMO = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TMO - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on clear, otherwise decrement towards zero while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/frame_buf_writer.sv
// Fills the frame-memory bank the serial generator is not reading, one slot
// per address with fixed source commutation and filler on source timeout.
module frame_buf_writer #(
  parameter int N_SRC = 4,
  parameter int DATA_W = m16_pkg::DATA_W,
  parameter int ADDR_W = m16_pkg::ADDR_W,
  parameter int TMO = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = m16_pkg::FILL_WORD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iSwitch,
  input  logic [N_SRC-1:0]        iReq,
  input  logic [N_SRC*DATA_W-1:0] iData,
  output logic [N_SRC-1:0]        oAck,
  output logic                    oWrEn,
  output logic [ADDR_W:0]         oWrAddr,
  output logic [DATA_W-1:0]       oWrData,
  output logic                    oBankReady,
  output logic                    oMiss,
  output logic                    oLate,
  output logic [7:0]              oMissCnt
);

  import m16_pkg::*;

  localparam int SEL_W = $clog2(N_SRC);

  wr_state_t          state_q, state_d;
  logic               sw_q, sw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         miss_acc_q, miss_acc_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               ready_q, ready_d;
  logic               miss_q, miss_d;
  logic               late_q, late_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;

  logic               toggle_s;
  logic [SEL_W-1:0]   src_s;
  logic               req_s;
  logic [DATA_W-1:0]  data_s;
  logic               open_s;
  logic               grant_s;
  logic               expire_s;
  logic               timeout_s;
  logic               timer_en_s;
  logic               timer_clr_s;

  // A toggle pre-empts any grant or timeout in the same cycle.
  assign toggle_s    = (iSwitch != sw_q);
  assign src_s       = addr_q[SEL_W-1:0];
  assign req_s       = iReq[src_s];
  assign open_s      = (state_q == WAIT) && !toggle_s;
  assign grant_s     = open_s && req_s;
  assign timer_en_s  = open_s && !req_s;
  assign timeout_s   = expire_s;
  assign timer_clr_s = toggle_s || grant_s || timeout_s;

  slot_timer #(.TMO(TMO)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clr_s),
    .en_i     (timer_en_s),
    .expire_o (expire_s)
  );

  // Word of the source owning the current slot.
  always_comb begin
    data_s = {DATA_W{1'b0}};
    for (int s = 0; s < N_SRC; s++) begin
      data_s = (src_s == SEL_W'(s)) ? iData[s*DATA_W +: DATA_W] : data_s;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    sw_d       = sw_q;
    addr_d     = addr_q;
    miss_acc_d = miss_acc_q;
    miss_cnt_d = miss_cnt_q;
    ack_d      = {N_SRC{1'b0}};
    wr_en_d    = 1'b0;
    wr_addr_d  = {(ADDR_W+1){1'b0}};
    wr_data_d  = {DATA_W{1'b0}};
    miss_d     = 1'b0;
    late_d     = 1'b0;
    ready_d    = (state_q == DONE) && !toggle_s;

    if (toggle_s) begin
      sw_d       = iSwitch;
      miss_cnt_d = miss_acc_q;
      miss_acc_d = 8'd0;
      addr_d     = {ADDR_W{1'b0}};
      state_d    = WAIT;
      late_d     = (state_q == WAIT);
    end else if (grant_s || timeout_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {~sw_q, addr_q};
      addr_d    = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (addr_q == {ADDR_W{1'b1}}) begin
        state_d = DONE;
      end else begin
        state_d = state_q;
      end
      if (grant_s) begin
        wr_data_d = data_s;
        ack_d     = {{(N_SRC-1){1'b0}}, 1'b1} << src_s;
      end else begin
        wr_data_d  = FILL_WORD;
        miss_d     = 1'b1;
        miss_acc_d = sat_inc8(miss_acc_q);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset re-aligns to the bank being read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT;
      sw_q       <= iSwitch;
      addr_q     <= {ADDR_W{1'b0}};
      miss_acc_q <= 8'd0;
      miss_cnt_q <= 8'd0;
      ack_q      <= {N_SRC{1'b0}};
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {(ADDR_W+1){1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      ready_q    <= 1'b0;
      miss_q     <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_q       <= sw_d;
      addr_q     <= addr_d;
      miss_acc_q <= miss_acc_d;
      miss_cnt_q <= miss_cnt_d;
      ack_q      <= ack_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ready_q    <= ready_d;
      miss_q     <= miss_d;
      late_q     <= late_d;
    end
  end

  assign oAck       = ack_q;
  assign oWrEn      = wr_en_q;
  assign oWrAddr    = wr_addr_q;
  assign oWrData    = wr_data_q;
  assign oBankReady = ready_q;
  assign oMiss      = miss_q;
  assign oLate      = late_q;
  assign oMissCnt   = miss_cnt_q;

endmodule

// File: tb/tb_frame_buf_writer.sv
// Bench for frame_buf_writer: directed scenarios plus randomized traffic,
// checked each cycle against a slot-level behavioural model.
module tb_frame_buf_writer;

  localparam int N   = 4;
  localparam int DW  = 12;
  localparam int AW  = 8;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          iSwitch;
  logic [N-1:0]  iReq;
  logic [N*DW-1:0] iData;
  logic [N-1:0]  oAck;
  logic          oWrEn;
  logic [AW:0]   oWrAddr;
  logic [DW-1:0] oWrData;
  logic          oBankReady;
  logic          oMiss;
  logic          oLate;
  logic [7:0]    oMissCnt;

  always #5 clk = ~clk;

  frame_buf_writer #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW), .TMO(TMO), .FILL_WORD(12'h000)) dut (
    .clk(clk), .reset(reset), .iSwitch(iSwitch), .iReq(iReq), .iData(iData),
    .oAck(oAck), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oBankReady(oBankReady), .oMiss(oMiss), .oLate(oLate), .oMissCnt(oMissCnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // model of the bank fill: which slot, how long it has waited, miss tallies
  bit m_sw, m_done;
  int m_addr, m_wait, m_miss, m_misscnt;
  bit e_wr, e_miss, e_late, e_ready;
  int e_addr, e_data, e_ack, e_misscnt;

  int mode [N];
  logic [DW-1:0] mem [512];
  int wr_cyc [512];
  int n_wr, n_miss;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic model_edge();
    int s;
    e_wr = 0; e_miss = 0; e_late = 0; e_ready = 0;
    e_addr = 0; e_data = 0; e_ack = 0;
    if (reset) begin
      m_sw = iSwitch; m_done = 0; m_addr = 0; m_wait = 0; m_miss = 0; m_misscnt = 0;
    end else if (iSwitch != m_sw) begin
      e_late = !m_done;
      m_misscnt = m_miss;
      m_miss = 0; m_addr = 0; m_wait = 0; m_done = 0; m_sw = iSwitch;
    end else if (m_done) begin
      e_ready = 1;
    end else begin
      s = m_addr % N;
      if (iReq[s]) begin
        e_wr = 1;
        e_ack = 1 << s;
        e_data = int'((iData >> (s * DW)) & 48'hFFF);
      end else if (m_wait == TMO - 1) begin
        e_wr = 1;
        e_miss = 1;
        e_data = 0;
        if (m_miss < 255) m_miss++;
      end else begin
        m_wait++;
      end
      if (e_wr) begin
        e_addr = (m_sw ? 0 : 256) + m_addr;
        m_addr++;
        m_wait = 0;
        if (m_addr == 256) begin
          m_addr = 0;
          m_done = 1;
        end
      end
    end
    e_misscnt = m_misscnt;
  endtask

  task automatic drive();
    logic [DW-1:0] pat;
    for (int s = 0; s < N; s++) begin
      case (mode[s])
        0: iReq[s] = 1'b0;
        1: begin
          pat = 12'(s * 12'h111);
          iReq[s] = 1'b1;
          iData[s*DW +: DW] = pat;
        end
        2: begin
          if (iReq[s]) begin
            if (e_ack[s]) begin
              if ($urandom_range(0, 1) == 0) iReq[s] = 1'b0;
              else iData[s*DW +: DW] = 12'($urandom);
            end
          end else if ($urandom_range(0, 3) == 0) begin
            iReq[s] = 1'b1;
            iData[s*DW +: DW] = 12'($urandom);
          end
        end
        default: iReq[s] = 1'b0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("wr_en", oWrEn, e_wr);
    check("ack", oAck, e_ack);
    check("miss", oMiss, e_miss);
    check("late", oLate, e_late);
    check("bank_ready", oBankReady, e_ready);
    check("miss_cnt", oMissCnt, e_misscnt);
    if (e_wr) begin
      check("wr_addr", oWrAddr, e_addr);
      check("wr_data", oWrData, e_data);
    end
    if (oWrEn === 1'b1) begin
      mem[oWrAddr] = oWrData;
      wr_cyc[oWrAddr] = cyc;
      n_wr++;
    end
    if (oMiss === 1'b1) n_miss++;
    drive();
  endtask

  task automatic wait_wr(input int a, input int bound, input string nm);
    int k = 0;
    logic [7:0] a8;
    a8 = a[7:0];
    do begin
      step();
      k++;
    end while (!(oWrEn === 1'b1 && oWrAddr[7:0] == a8) && k < bound);
    if (!(oWrEn === 1'b1 && oWrAddr[7:0] == a8)) bound_fail(nm);
  endtask

  task automatic wait_ready(input int bound, input string nm);
    int k = 0;
    do begin
      step();
      k++;
    end while (oBankReady !== 1'b1 && k < bound);
    if (oBankReady !== 1'b1) bound_fail(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; iSwitch = 1'b0; iReq = '0; iData = '0;
    for (int s = 0; s < N; s++) mode[s] = 0;
    step();
    step();
    check("rst_wr_en", oWrEn, 0);
    check("rst_wr_addr", oWrAddr, 0);
    check("rst_miss_cnt", oMissCnt, 0);
    check("rst_ready", oBankReady, 0);

    // all sources always ready: one word per cycle into bank 1
    reset = 1'b0;
    for (int s = 0; s < N; s++) mode[s] = 1;
    drive();
    n_wr = 0; n_miss = 0;
    wait_ready(400, "s1_ready");
    check("s1_n_wr", n_wr, 256);
    check("s1_n_miss", n_miss, 0);
    check("s1_span", wr_cyc[511] - wr_cyc[256], 255);
    check("s1_mem0", mem[256], 12'h000);
    check("s1_mem1", mem[257], 12'h111);
    check("s1_mem3", mem[259], 12'h333);
    check("s1_mem254", mem[510], 12'h222);
    step();
    check("s1_ready_hold", oBankReady, 1);
    check("s1_no_wr_done", oWrEn, 0);

    // toggle after completion: not late, next write at bank 0 addr 0
    iSwitch = 1'b1;
    step();
    check("s3_late", oLate, 0);
    check("s3_no_wr", oWrEn, 0);
    step();
    check("s3_wr_en", oWrEn, 1);
    check("s3_wr_addr", oWrAddr, 9'h000);
    check("s3_ack", oAck, 4'b0001);

    // toggle while writing at addr 100
    wait_wr(100, 300, "s4_addr100");
    iSwitch = 1'b0;
    step();
    check("s4_late", oLate, 1);
    check("s4_no_wr", oWrEn, 0);
    check("s4_no_ack", oAck, 0);
    step();
    check("s4_restart_en", oWrEn, 1);
    check("s4_restart_addr", oWrAddr, 9'h100);

    // source 2 silent for a whole bank
    mode[2] = 0;
    drive();
    n_miss = 0;
    wait_ready(4000, "s2_ready");
    check("s2_n_miss", n_miss, 64);
    check("s2_tmo_gap", wr_cyc[258] - wr_cyc[257], 32);
    check("s2_fill", mem[262], 12'h000);
    check("s2_src3", mem[263], 12'h333);
    iSwitch = 1'b1;
    mode[2] = 1;
    drive();
    step();
    check("s2_miss_cnt", oMissCnt, 64);
    check("s2_late", oLate, 0);

    // toggle coinciding with the grant for addr 255
    wait_wr(254, 300, "s5_addr254");
    iSwitch = 1'b0;
    step();
    check("s5_late", oLate, 1);
    check("s5_no_wr", oWrEn, 0);
    check("s5_no_ack", oAck, 0);
    check("s5_not_ready", oBankReady, 0);
    step();
    check("s5_not_ready2", oBankReady, 0);
    check("s5_miss_cnt", oMissCnt, 0);

    // reset at addr 50 with 10 misses accumulated
    mode[2] = 0;
    drive();
    n_miss = 0;
    k = 0;
    while (n_miss < 10 && k < 1000) begin
      step();
      k++;
    end
    if (n_miss < 10) bound_fail("s6_misses");
    mode[2] = 1;
    drive();
    wait_wr(49, 200, "s6_addr49");
    reset = 1'b1;
    step();
    check("s6_wr_en", oWrEn, 0);
    check("s6_ack", oAck, 0);
    check("s6_wr_addr", oWrAddr, 0);
    check("s6_wr_data", oWrData, 0);
    check("s6_miss", oMiss, 0);
    check("s6_late", oLate, 0);
    check("s6_ready", oBankReady, 0);
    check("s6_miss_cnt", oMissCnt, 0);
    reset = 1'b0;
    step();
    check("s6_restart_en", oWrEn, 1);
    check("s6_restart_addr", oWrAddr, 9'h100);
    wait_ready(400, "s6_ready");
    iSwitch = 1'b1;
    step();
    check("s6_miss_cnt_after", oMissCnt, 0);
    check("s6_late_after", oLate, 0);

    // randomized traffic, toggles and occasional resets
    for (int s = 0; s < N; s++) mode[s] = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      reset = 1'b0;
      if (i % 500 == 0) begin
        for (int s = 0; s < N; s++) mode[s] = $urandom_range(0, 5) == 0 ? 0 : 2;
      end
      if ((oBankReady && $urandom_range(0, 19) == 0) || $urandom_range(0, 399) == 0)
        iSwitch = ~iSwitch;
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
